// File: rtl/data_mod_pkg.sv
// Shared types and sizing helpers for the data gearbox.
// FSM state encoding gains a FLUSH state only when DATA_GEARBOX_FLUSH_EN is defined.
// Helpers size the bit buffer and its fill counter from the word/symbol widths.
package data_mod_pkg;

`ifdef DATA_GEARBOX_FLUSH_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;
`endif

  // Buffer must hold one full symbol plus one incoming word.
  function automatic int buf_w(input int in_w, input int out_w);
    return in_w + out_w;
  endfunction

  // Fill counter counts 0..BUF_W inclusive.
  function automatic int fill_w(input int in_w, input int out_w);
    return $clog2(in_w + out_w + 1);
  endfunction

endpackage

// File: rtl/data_gearbox.sv
// Purpose: repacks IN_W-bit words from a FWFT source into OUT_W-bit symbols (LSB- or MSB-first).
// Latency: one clock from the accepting edge to mod_en once a full symbol is buffered.
// Backpressure: mod_stall freezes emission/dmod; rd keeps accepting while the buffer has room.
// Optional residual flush (flush port, FLUSH state) is compiled in with DATA_GEARBOX_FLUSH_EN.
module data_gearbox
  import data_mod_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 5,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_empty,
  input  logic [IN_W-1:0]                   data_in,
  output logic                              rd,
  input  logic                              mod_stall,
`ifdef DATA_GEARBOX_FLUSH_EN
  input  logic                              flush,
`endif
  output logic [OUT_W-1:0]                  dmod,
  output logic                              mod_en,
  output logic [$clog2(IN_W+OUT_W+1)-1:0]   fill
);

  localparam int BUF_W  = buf_w(IN_W, OUT_W);
  localparam int FILL_W = fill_w(IN_W, OUT_W);

  typedef logic [FILL_W-1:0] fill_t;
  typedef logic [FILL_W:0]   cnt_t;
  typedef logic [BUF_W-1:0]  buf_t;

  localparam fill_t C_OUT_W = fill_t'(OUT_W);
  localparam fill_t C_IN_WF = fill_t'(IN_W);
  localparam cnt_t  C_IN_W  = cnt_t'(IN_W);
  localparam cnt_t  C_BUF_W = cnt_t'(BUF_W);

  // Buffer holds bits in transmission order: bit 0 is the oldest, bits at or above r_fill are zero.
  state_t            r_state;
  buf_t              r_buf;
  fill_t             r_fill;
  logic [OUT_W-1:0]  r_dmod;
  logic              r_mod_en;

  logic [IN_W-1:0]   w_in_ord;
  logic [OUT_W-1:0]  w_sym;
  logic              w_flushing;
  logic              w_pop_full;
  logic              w_pop_res;
  logic              w_emit;
  logic              w_rd;
  fill_t             w_pop_cnt;
  fill_t             w_after_pop;
  fill_t             w_fill_nxt;
  buf_t              w_buf_nxt;
`ifdef DATA_GEARBOX_FLUSH_EN
  logic              w_flush_req;
`endif

  // FLUSH-state decode and flush request qualification (flush with an empty buffer is ignored)
  always_comb begin
    w_flushing = 1'b0;
`ifdef DATA_GEARBOX_FLUSH_EN
    w_flushing  = (r_state == ST_FLUSH);
    w_flush_req = flush && (r_fill != '0);
`endif
  end

  // Reorder input words and output symbols so transmission order always maps to buffer bit 0 upward
  always_comb begin
    w_in_ord = data_in;
    w_sym    = r_buf[OUT_W-1:0];
    if (MSB_FIRST) begin
      for (int i = 0; i < IN_W; i++) begin
        w_in_ord[i] = data_in[IN_W-1-i];
      end
      for (int j = 0; j < OUT_W; j++) begin
        w_sym[OUT_W-1-j] = r_buf[j];
      end
    end
  end

  // Pop decision, read strobe and next buffer/fill; push lands directly behind the surviving bits
  always_comb begin
    w_pop_full  = (r_fill >= C_OUT_W) && !mod_stall;
    w_pop_res   = w_flushing && (r_fill != '0) && (r_fill < C_OUT_W) && !mod_stall;
    w_emit      = w_pop_full || w_pop_res;
    w_pop_cnt   = '0;
    if (w_pop_full) begin
      w_pop_cnt = C_OUT_W;
    end else if (w_pop_res) begin
      w_pop_cnt = r_fill;
    end
    w_after_pop = r_fill - w_pop_cnt;
    w_rd        = reset_n && !in_empty && !w_flushing &&
                  ((cnt_t'(w_after_pop) + C_IN_W) <= C_BUF_W);
    w_buf_nxt   = r_buf >> w_pop_cnt;
    w_fill_nxt  = w_after_pop;
    if (w_rd) begin
      w_buf_nxt  = w_buf_nxt | (buf_t'(w_in_ord) << w_after_pop);
      w_fill_nxt = w_after_pop + C_IN_WF;
    end
  end

  assign rd     = w_rd;
  assign dmod   = r_dmod;
  assign mod_en = r_mod_en;
  assign fill   = r_fill;

  // FSM, bit buffer and registered symbol output; residual padding comes from the zeroed upper bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_buf    <= '0;
      r_fill   <= '0;
      r_dmod   <= '0;
      r_mod_en <= 1'b0;
    end else begin
      r_buf    <= w_buf_nxt;
      r_fill   <= w_fill_nxt;
      r_mod_en <= w_emit;
      if (w_emit) begin
        r_dmod <= w_sym;
      end
      case (r_state)
`ifdef DATA_GEARBOX_FLUSH_EN
        ST_FLUSH: begin
          if (w_fill_nxt == '0) begin
            r_state <= ST_IDLE;
          end
        end
`endif
        ST_RUN: begin
          if (w_fill_nxt == '0) begin
            r_state <= ST_IDLE;
`ifdef DATA_GEARBOX_FLUSH_EN
          end else if (w_flush_req) begin
            r_state <= ST_FLUSH;
`endif
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= (w_fill_nxt == '0) ? ST_IDLE : ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_gearbox.sv
// Bench for data_gearbox: three instances (8->5 LSB-first, 8->5 MSB-first, 8->8 pass-through)
// driven from per-instance FWFT sources, checked each cycle against a bit-queue model,
// plus literal symbol sequences for the documented examples.
module tb_data_gearbox;

  localparam int ND = 3;
  localparam int IW = 8;
  localparam int P_OW  [ND] = '{5, 5, 8};
  localparam bit P_MSB [ND] = '{1'b0, 1'b1, 1'b0};
`ifdef DATA_GEARBOX_FLUSH_EN
  localparam bit HAS_FLUSH = 1'b1;
`else
  localparam bit HAS_FLUSH = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       mod_stall;
  logic       flush;
  logic       in_empty [ND];
  logic [7:0] data_in  [ND];
  logic       rd0, rd1, rd2;
  logic [4:0] dmod0, dmod1;
  logic [7:0] dmod2;
  logic       en0, en1, en2;
  logic [3:0] fill0, fill1;
  logic [4:0] fill2;

  data_gearbox #(.IN_W(8), .OUT_W(5), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .in_empty(in_empty[0]), .data_in(data_in[0]),
    .rd(rd0), .mod_stall(mod_stall),
`ifdef DATA_GEARBOX_FLUSH_EN
    .flush(flush),
`endif
    .dmod(dmod0), .mod_en(en0), .fill(fill0));

  data_gearbox #(.IN_W(8), .OUT_W(5), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .in_empty(in_empty[1]), .data_in(data_in[1]),
    .rd(rd1), .mod_stall(mod_stall),
`ifdef DATA_GEARBOX_FLUSH_EN
    .flush(flush),
`endif
    .dmod(dmod1), .mod_en(en1), .fill(fill1));

  data_gearbox #(.IN_W(8), .OUT_W(8), .MSB_FIRST(1'b0)) u_pass (
    .clk(clk), .reset_n(reset_n), .in_empty(in_empty[2]), .data_in(data_in[2]),
    .rd(rd2), .mod_stall(mod_stall),
`ifdef DATA_GEARBOX_FLUSH_EN
    .flush(flush),
`endif
    .dmod(dmod2), .mod_en(en2), .fill(fill2));

  // Sources, model state and output logs
  logic [7:0]  src [ND][256];
  int          sh [ND];
  int          st [ND];
  bit          gap [ND];
  logic [63:0] mb [ND];
  int          mc [ND];
  bit          mfl [ND];
  logic [31:0] exp_dmod [ND];
  bit          e_rd [ND];
  bit          e_emit [ND];
  logic [31:0] e_sym [ND];
  int          e_pop [ND];
  int          lg [ND][64];
  int          lc [ND][64];
  int          ln [ND];
  int          cyc;
  int          n_cmp;
  int          n_bad;

  function automatic logic [31:0] get_rd(input int k);
    case (k)
      0: return 32'(rd0);
      1: return 32'(rd1);
      default: return 32'(rd2);
    endcase
  endfunction

  function automatic logic [31:0] get_en(input int k);
    case (k)
      0: return 32'(en0);
      1: return 32'(en1);
      default: return 32'(en2);
    endcase
  endfunction

  function automatic logic [31:0] get_dmod(input int k);
    case (k)
      0: return 32'(dmod0);
      1: return 32'(dmod1);
      default: return 32'(dmod2);
    endcase
  endfunction

  function automatic logic [31:0] get_fill(input int k);
    case (k)
      0: return 32'(fill0);
      1: return 32'(fill1);
      default: return 32'(fill2);
    endcase
  endfunction

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic push_word(input int k, input logic [7:0] w);
    src[k][st[k] % 256] = w;
    st[k]++;
  endtask

  task automatic clear_logs();
    for (int k = 0; k < ND; k++) ln[k] = 0;
  endtask

  // Before the edge: decide what must be emitted and whether a word may be taken
  task automatic model_pre(input int k);
    int ow;
    bit b;
    ow = P_OW[k];
    e_pop[k] = 0;
    e_sym[k] = '0;
    if (!mod_stall) begin
      if (mc[k] >= ow) e_pop[k] = ow;
      else if (mfl[k] && mc[k] > 0) e_pop[k] = mc[k];
    end
    e_emit[k] = (e_pop[k] > 0);
    for (int j = 0; j < ow; j++) begin
      b = (j < e_pop[k]) ? mb[k][j] : 1'b0;
      if (P_MSB[k]) e_sym[k][ow-1-j] = b;
      else e_sym[k][j] = b;
    end
    e_rd[k] = !mfl[k] && !in_empty[k] && (mc[k] - e_pop[k] + IW <= IW + ow);
    check("rd", k, get_rd(k), 32'(e_rd[k]));
  endtask

  // After the edge: advance the bit queue and compare registered outputs
  task automatic model_post(input int k);
    int  old;
    bit  fl_in;
    old   = mc[k];
    fl_in = HAS_FLUSH && flush;
    mb[k] = mb[k] >> e_pop[k];
    mc[k] = mc[k] - e_pop[k];
    if (e_rd[k]) begin
      for (int j = 0; j < IW; j++) begin
        mb[k][mc[k]+j] = P_MSB[k] ? data_in[k][IW-1-j] : data_in[k][j];
      end
      mc[k] = mc[k] + IW;
      sh[k]++;
    end
    if (mfl[k]) mfl[k] = (mc[k] > 0);
    else mfl[k] = fl_in && (old > 0) && (mc[k] > 0);
    if (e_emit[k]) exp_dmod[k] = e_sym[k];
    check("mod_en", k, get_en(k), 32'(e_emit[k]));
    check("dmod", k, get_dmod(k), exp_dmod[k]);
    check("fill", k, get_fill(k), 32'(mc[k]));
    if (get_en(k) === 32'd1 && ln[k] < 64) begin
      lg[k][ln[k]] = int'(get_dmod(k));
      lc[k][ln[k]] = cyc;
      ln[k]++;
    end
  endtask

  // One clock: drive at the falling edge, check rd, then check outputs just after the rising edge
  task automatic step();
    bit avail;
    for (int k = 0; k < ND; k++) begin
      avail       = (st[k] != sh[k]) && !gap[k];
      in_empty[k] = !avail;
      data_in[k]  = avail ? src[k][sh[k] % 256] : 8'h00;
    end
    #1;
    for (int k = 0; k < ND; k++) model_pre(k);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < ND; k++) model_post(k);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int k = 0; k < ND; k++) begin
      in_empty[k] = 1'b0;
      data_in[k]  = 8'hFF;
    end
    #1;
    for (int k = 0; k < ND; k++) begin
      check("rst_mod_en", k, get_en(k), 32'd0);
      check("rst_fill", k, get_fill(k), 32'd0);
      check("rst_rd", k, get_rd(k), 32'd0);
      check("rst_dmod", k, get_dmod(k), 32'd0);
      mb[k]       = '0;
      mc[k]       = 0;
      mfl[k]      = 1'b0;
      exp_dmod[k] = '0;
      sh[k]       = st[k];
      gap[k]      = 1'b0;
    end
    mod_stall = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp33 [8];
    logic [7:0] wr [4];
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    reset_n   = 1'b1;
    mod_stall = 1'b0;
    flush     = 1'b0;
    for (int k = 0; k < ND; k++) begin
      in_empty[k] = 1'b1;
      data_in[k]  = 8'h00;
      sh[k] = 0;
      st[k] = 0;
      gap[k] = 1'b0;
      ln[k] = 0;
    end
    #2;
    do_reset();

    // Documented streams on all three instances at once
    clear_logs();
    push_word(0, 8'hFF); push_word(0, 8'h00); push_word(0, 8'hFF);
    push_word(0, 8'h00); push_word(0, 8'hFF);
    push_word(1, 8'h80); push_word(1, 8'h00);
    push_word(2, 8'h12); push_word(2, 8'h34);
    repeat (16) step();
    exp33 = '{8'h1F, 8'h07, 8'h00, 8'h1E, 8'h0F, 8'h00, 8'h1C, 8'h1F};
    check("lsb_count", 0, 32'(ln[0]), 32'd8);
    for (int i = 0; i < 8; i++) check("lsb_seq", 0, 32'(lg[0][i]), 32'(exp33[i]));
    check("lsb_fill_end", 0, get_fill(0), 32'd0);
    check("msb_sym0", 1, 32'(lg[1][0]), 32'h10);
    check("msb_sym1", 1, 32'(lg[1][1]), 32'h00);
    check("pass_sym0", 2, 32'(lg[2][0]), 32'h12);
    check("pass_sym1", 2, 32'(lg[2][1]), 32'h34);
    check("pass_rate", 2, 32'(lc[2][1] - lc[2][0]), 32'd1);

    // Alternating source brings the 8->5 buffer to 7 bits, then reset mid-stream
    wr = '{8'h3C, 8'hA5, 8'h5A, 8'hC3};
    for (int i = 0; i < 4; i++) push_word(0, wr[i]);
    for (int i = 0; i < 8; i++) begin
      gap[0] = (i % 2) == 1;
      step();
    end
    gap[0] = 1'b0;
    check("fill7", 0, get_fill(0), 32'd7);
    do_reset();
    clear_logs();
    push_word(0, 8'h0F);
    repeat (4) step();
    check("post_rst_sym", 0, 32'(lg[0][0]), 32'h0F);
    check("post_rst_fill", 0, get_fill(0), 32'd3);

    // Backpressure: stalled sink with a continuously ready source
    do_reset();
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      push_word(0, 8'(i * 37 + 5));
      push_word(2, 8'(i * 11 + 3));
    end
    mod_stall = 1'b1;
    repeat (4) step();
    check("stall_fill", 0, get_fill(0), 32'd8);
    check("stall_fill_pass", 2, get_fill(2), 32'd16);
    check("stall_no_sym", 0, 32'(ln[0]), 32'd0);
    mod_stall = 1'b0;
    repeat (24) step();
    check("stall_count", 0, 32'(ln[0]), 32'd9);
    check("stall_count_pass", 2, 32'(ln[2]), 32'd6);

`ifdef DATA_GEARBOX_FLUSH_EN
    // Flush emits the full symbol first, then the zero-padded residual
    do_reset();
    clear_logs();
    push_word(0, 8'hA5);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    check("flush_count", 0, 32'(ln[0]), 32'd2);
    check("flush_sym0", 0, 32'(lg[0][0]), 32'h05);
    check("flush_sym1", 0, 32'(lg[0][1]), 32'h05);
    check("flush_fill", 0, get_fill(0), 32'd0);
`endif

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < ND; k++) begin
        if (st[k] - sh[k] < 8) push_word(k, 8'($urandom));
        gap[k] = ($urandom_range(0, 3) == 0);
      end
      mod_stall = ($urandom_range(0, 3) == 0);
      flush     = HAS_FLUSH && ($urandom_range(0, 19) == 0);
      step();
    end
    mod_stall = 1'b0;
    flush     = 1'b0;
    for (int k = 0; k < ND; k++) gap[k] = 1'b0;
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_gearbox.md
DATA_GEARBOX -- requirements
Module: data_gearbox

Interface
REQ-001 SHALL have parameter IN_W, default 8: input word width in bits, range 2..32.
REQ-002 SHALL have parameter OUT_W, default 5: output symbol width in bits, range 1..32.
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 = LSB-first bit order, 1 = MSB-first bit order.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port in_empty  in  1  source empty; low means data_in is valid (first-word-fall-through).
REQ-007 SHALL have port data_in  in  IN_W  input word.
REQ-008 SHALL have port rd  out  1  combinational read strobe; data_in is consumed at the edge where rd=1.
REQ-009 SHALL have port mod_stall  in  1  sink backpressure; high blocks symbol emission.
REQ-010 SHALL have port flush  in  1  single-cycle request to emit the zero-padded residual (present only with DATA_GEARBOX_FLUSH_EN).
REQ-011 SHALL have port dmod  out  OUT_W  registered output symbol.
REQ-012 SHALL have port mod_en  out  1  registered one-cycle valid per symbol.
REQ-013 SHALL have port fill  out  $clog2(IN_W+OUT_W+1)  bits currently held in the buffer.

Function
REQ-014 SHALL hold bits in a buffer of BUF_W = IN_W+OUT_W bits, tracked by the fill counter.
REQ-015 SHALL, when fill>=OUT_W and mod_stall=0, register the oldest OUT_W bits onto dmod, set mod_en=1 and reduce fill by OUT_W; otherwise drive mod_en=0 and hold dmod.
REQ-016 SHALL drive rd = !in_empty && (fill - pop + IN_W <= BUF_W), where pop = OUT_W when REQ-015 emits that cycle and 0 otherwise.
REQ-017 SHALL, on an edge with rd=1, append data_in behind the existing bits, so push and pop can occur in the same cycle.
REQ-018 SHALL, with MSB_FIRST=0, transmit data_in[0] first, with the first-transmitted bit landing in dmod[0].
REQ-019 SHALL, with MSB_FIRST=1, transmit data_in[IN_W-1] first, with the first-transmitted bit landing in dmod[OUT_W-1].
REQ-020 SHALL run the FSM IDLE(fill=0) -> RUN(fill>0) -> FLUSH -> IDLE.
REQ-021 SHALL, in FLUSH, keep rd=0; when mod_stall=0, emit the remaining fill bits zero-padded to OUT_W, clear fill and return to IDLE.
REQ-022 SHALL ignore flush when fill=0.
REQ-023 SHALL, when flush arrives with fill>=OUT_W, first drain full symbols, then emit the padded residual.
REQ-024 SHALL hold all state and outputs while mod_stall=1; rd then depends only on free space.
REQ-025 SHALL deliver latency of one clock from the accepting edge to mod_en when fill+IN_W>=OUT_W.
REQ-026 SHALL sustain one symbol per clock while the source is non-empty and OUT_W<=IN_W.

Reset
REQ-027 SHALL, on reset_n low, immediately clear buffer, fill, dmod and mod_en, set state to IDLE and force rd low.
REQ-028 SHALL discard buffered bits without emitting them when reset asserts mid-operation.

Configuration
REQ-029 SHALL, with DATA_GEARBOX_FLUSH_EN defined, include the flush port, the FLUSH state and REQ-021..REQ-023.
REQ-030 SHALL, without DATA_GEARBOX_FLUSH_EN, omit the flush port and FLUSH state, retaining residual bits until further input completes a symbol.

Structure
REQ-031 SHALL place the FSM state enum and the BUF_W/fill-width helper functions in shared package data_mod_pkg.
REQ-032 SHALL implement as a single module, with no sub-module required.

Verification
REQ-033 SHALL cover defaults LSB-first: bytes 0xFF,0x00,0xFF,0x00,0xFF -> dmod 0x1F,0x07,0x00,0x1E,0x0F,0x00,0x1C,0x1F, then fill=0.
REQ-034 SHALL cover flush (FLUSH_EN): byte 0xA5 then flush -> 0x05, then padded 0x05, fill=0, state IDLE.
REQ-035 SHALL cover backpressure: mod_stall=1 with continuous input -> rd drops once fill+8>13, and no symbols are lost or duplicated after release.
REQ-036 SHALL cover reset mid-stream: reset_n low with fill=7 -> mod_en=0, fill=0, rd=0 immediately; next stream decodes from bit 0.
REQ-037 SHALL cover MSB_FIRST=1: byte 0x80 then 0x00 -> first dmod 0x10, second 0x00.
REQ-038 SHALL cover IN_W=8, OUT_W=8 pass-through: bytes 0x12,0x34 -> dmod 0x12,0x34 at one symbol per clock.
